// File: rtl/fetch_pkg.sv
// Shared constants, entry layout and width helper for the instruction fetch unit.
// The optional misalign trap (FETCH_MISALIGN_TRAP_EN) lives in instruction_fetch_unit.
package fetch_pkg;

  localparam int unsigned PC_STEP         = 4;
  localparam int unsigned INSTR_W_DEFAULT = 32;

  // Prefetch FIFO entry at the default instruction width.
  typedef struct packed {
    logic [INSTR_W_DEFAULT-1:0] instr;
  } fetch_entry_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result = 0;
    for (int unsigned w = 1; w < value; w = w << 1) result++;
    return result;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with clear; DEPTH must be a power of two so the
// pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PTR_W = clog2(DEPTH),
  localparam int unsigned CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Decoupled fetch stage: PC generation, in-order memory requests, prefetch FIFO
// and redirect flush. Define FETCH_MISALIGN_TRAP_EN to trap misaligned targets.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INSTR_W  = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_branch,
  input  logic [ADDR_W-1:0]  pc_jump,
  input  logic               PCSrc,
  input  logic               jump,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  pc_incrementado
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic               if_misalign
`endif
);

  localparam int unsigned CNT_W = clog2(DEPTH + 1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] head_pc;
  logic [ADDR_W-1:0] raw_target;
  logic [ADDR_W-1:0] target;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop_cnt;
  logic              redirect;
  logic              has_room;
  logic              issue;
  logic              push;
  logic              pop;
  logic              trap;
  entry_t            push_entry;
  entry_t            head_entry;

  // Single +4 adder shape shared by the fetch and head PC paths.
  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(PC_STEP);
  endfunction

  assign redirect   = PCSrc | jump;
  assign raw_target = PCSrc ? pc_branch : pc_jump;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        trap_q <= 1'b0;
    else if (redirect) trap_q <= |raw_target[1:0];
  end

  assign target      = raw_target;
  assign trap        = trap_q;
  assign if_misalign = trap_q;
`else
  assign target = raw_target & ~ADDR_W'(3);
  assign trap   = 1'b0;
`endif

  // Entries already buffered plus those still in flight must fit the FIFO.
  assign has_room       = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CNT_W + 1)'(DEPTH);
  assign imem_req_valid = reset & ~redirect & has_room & ~trap;
  assign imem_req_addr  = fetch_pc;
  assign issue          = imem_req_valid & imem_req_ready;

  assign push             = imem_rsp_valid & (drop_cnt == '0) & ~redirect & ~trap;
  assign push_entry.instr = imem_rsp_data;

  assign if_valid        = ~redirect & (trap | (fifo_count != '0));
  assign pop             = if_valid & if_ready & ~trap;
  assign if_instr        = trap ? '0 : head_entry.instr;
  assign if_pc           = head_pc;
  assign pc_incrementado = pc_next(head_pc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      head_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(imem_rsp_valid);
      if (redirect) begin
        fetch_pc <= target;
        head_pc  <= target;
        // Everything still in flight after this cycle belongs to the old path.
        drop_cnt <= outstanding - CNT_W'(imem_rsp_valid);
      end else begin
        if (issue) fetch_pc <= pc_next(fetch_pc);
        if (pop)   head_pc  <= pc_next(head_pc);
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (redirect),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .head      (head_entry),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: in-order memory model with
// variable latency and a sequential PC/instruction reference stream.
module tb_instruction_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_branch, pc_jump;
  logic        PCSrc, jump;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc, pc_incrementado;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        if_misalign;
`endif

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          lat_rand = 0;
  int          ready_pct = 100;
  int          pop_pct = 100;
  int          pops = 0;
  int          pops0;
  bit          popped_now;
  logic [31:0] exp_pc, exp_req, last_pop_pc, last_pop_incr;

  instruction_fetch_unit #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_branch       (pc_branch),
    .pc_jump         (pc_jump),
    .PCSrc           (PCSrc),
    .jump            (jump),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .pc_incrementado (pc_incrementado)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .if_misalign     (if_misalign)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later, update the model.
  task automatic cycle(input logic br, input logic jp, input logic [31:0] tbr, input logic [31:0] tjp);
    logic [31:0] tgt;
    logic fire, popv, rsp, redir;
    PCSrc          = br;
    jump           = jp;
    pc_branch      = tbr;
    pc_jump        = tjp;
    imem_req_ready = (int'($urandom_range(99)) < ready_pct);
    if_ready       = (int'($urandom_range(99)) < pop_pct);
    rsp            = (q.size() != 0) && (q[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(q[0].addr) : 32'h0;
    #1;
    redir      = br | jp;
    fire       = imem_req_valid & imem_req_ready;
    popv       = if_valid & if_ready;
    popped_now = popv;
    if (redir) begin
      check("redirect_no_issue", 32'(imem_req_valid), 32'd0);
      check("redirect_no_pop", 32'(if_valid), 32'd0);
    end
    if (fire) begin
      check("req_addr", imem_req_addr, exp_req);
      q.push_back('{addr: imem_req_addr, due: cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat)});
      exp_req += 32'd4;
    end
    if (popv) begin
      check("if_pc", if_pc, exp_pc);
      check("if_instr", if_instr, mem_word(exp_pc));
      check("pc_incrementado", pc_incrementado, exp_pc + 32'd4);
      last_pop_pc   = if_pc;
      last_pop_incr = pc_incrementado;
      exp_pc += 32'd4;
      pops++;
    end
    if (rsp) q.delete(0);
    check("outstanding_le_depth", 32'(q.size() <= DEPTH), 32'd1);
    if (redir) begin
      tgt = br ? tbr : tjp;
`ifndef FETCH_MISALIGN_TRAP_EN
      tgt[1:0] = 2'b00;
`endif
      exp_pc  = tgt;
      exp_req = tgt;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_pop(input string tag, input int limit);
    int n = 0;
    popped_now = 1'b0;
    do begin
      cycle(1'b0, 1'b0, 32'h0, 32'h0);
      n++;
    end while (!popped_now && n < limit);
    check({tag, "_pop_timeout"}, 32'(popped_now), 32'd1);
  endtask

  task automatic wait_inflight(input string tag, input int need);
    int n = 0;
    while (q.size() < need && n < 40) begin
      cycle(1'b0, 1'b0, 32'h0, 32'h0);
      n++;
    end
    check({tag, "_inflight"}, 32'(q.size() >= need), 32'd1);
  endtask

  initial begin
    logic b, j;
    reset = 1'b0; PCSrc = 1'b0; jump = 1'b0; pc_branch = '0; pc_jump = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b0;
    exp_pc = RESET_PC; exp_req = RESET_PC;
    repeat (2) @(negedge clk);
    #1;
    check("reset_req_valid", 32'(imem_req_valid), 32'd0);
    check("reset_if_valid", 32'(if_valid), 32'd0);
    check("reset_if_pc", if_pc, RESET_PC);
    check("reset_pc_incr", pc_incrementado, RESET_PC + 32'd4);
    reset = 1'b1;
    @(negedge clk);

    // Streaming with 1-cycle memory.
    repeat (20) cycle(1'b0, 1'b0, 32'h0, 32'h0);
    check("stream_progress", 32'(pops >= 15), 32'd1);

    // Decode stall fills the FIFO and throttles requests.
    pop_pct = 0;
    repeat (10) cycle(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("stall_req_blocked", 32'(imem_req_valid), 32'd0);
    check("stall_no_inflight", 32'(q.size()), 32'd0);
    check("stall_head_valid", 32'(if_valid), 32'd1);
    pop_pct = 100;
    pops0 = pops;
    repeat (15) cycle(1'b0, 1'b0, 32'h0, 32'h0);
    check("stall_release_progress", 32'(pops - pops0 >= 10), 32'd1);

    // Branch with requests in flight on a 3-cycle memory.
    lat = 3;
    wait_inflight("branch", 3);
    cycle(1'b1, 1'b0, 32'h100, 32'h0);
    wait_pop("branch", 20);
    check("branch_first_pc", last_pop_pc, 32'h100);
    check("branch_first_incr", last_pop_incr, 32'h104);

    // Branch beats jump when both are asserted.
    lat = 1;
    cycle(1'b1, 1'b1, 32'h40, 32'h80);
    wait_pop("both", 20);
    check("both_branch_wins", last_pop_pc, 32'h40);

    // Second redirect while stale responses are still being dropped.
    lat = 3;
    wait_inflight("double", 2);
    cycle(1'b1, 1'b0, 32'h200, 32'h0);
    cycle(1'b0, 1'b1, 32'h0, 32'h300);
    wait_pop("double", 20);
    check("double_last_wins", last_pop_pc, 32'h300);

`ifndef FETCH_MISALIGN_TRAP_EN
    // Without the trap, low target bits are ignored.
    lat = 1;
    cycle(1'b0, 1'b1, 32'h0, 32'h102);
    wait_pop("misalign_mask", 20);
    check("misalign_masked_pc", last_pop_pc, 32'h100);
`endif

    // Random backpressure, latency, stalls and occasional redirects.
    lat_rand = 1'b1; ready_pct = 50; pop_pct = 70;
    pops0 = pops;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(99) < 3) begin
        b = 1'($urandom_range(1));
        j = b ? 1'($urandom_range(1)) : 1'b1;
        cycle(b, j, $urandom & 32'h0000_FFFC, $urandom & 32'h0000_FFFC);
      end else begin
        cycle(1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    check("random_progress", 32'(pops - pops0 > 50), 32'd1);

    // Reset mid-stream.
    lat_rand = 1'b0; lat = 1; ready_pct = 100; pop_pct = 100;
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    check("midreset_req_valid", 32'(imem_req_valid), 32'd0);
    check("midreset_if_valid", 32'(if_valid), 32'd0);
    q.delete();
    exp_pc = RESET_PC; exp_req = RESET_PC;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    pops0 = pops;
    repeat (10) cycle(1'b0, 1'b0, 32'h0, 32'h0);
    check("after_reset_progress", 32'(pops - pops0 >= 6), 32'd1);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned jump enters the trap and stays there across pops.
    cycle(1'b0, 1'b1, 32'h0, 32'h102);
    PCSrc = 1'b0; jump = 1'b0; imem_rsp_valid = 1'b0; if_ready = 1'b1;
    #1;
    check("trap_misalign", 32'(if_misalign), 32'd1);
    check("trap_if_valid", 32'(if_valid), 32'd1);
    check("trap_if_pc", if_pc, 32'h102);
    check("trap_if_instr", if_instr, 32'h0);
    check("trap_no_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    #1;
    check("trap_sticky_valid", 32'(if_valid), 32'd1);
    check("trap_sticky_misalign", 32'(if_misalign), 32'd1);
    @(negedge clk);
    jump = 1'b1; pc_jump = 32'h0;
    @(negedge clk);
    jump = 1'b0;
    #1;
    check("trap_cleared", 32'(if_misalign), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
